// File: rtl/sm_input_filter.sv
// sm_input_filter: multi-channel input conditioner.
// Per channel: SYNC_STAGES-deep synchroniser, run-time programmable stability
// counter (stable_len, 0 treated as 1), and registered one-cycle rise/fall strobes.
// Optional sticky change flags are built when SM_INPUT_FILTER_EVT_EN is defined;
// otherwise evt_flags/evt_any are tied to 0 and evt_clr is ignored.
module sm_input_filter #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      CNT_W       = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic [CNT_W-1:0] stable_len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] evt_flags,
  output logic             evt_any
);

  localparam logic [CNT_W:0] ONE_W = 1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_nxt  [WIDTH];
  logic [CNT_W:0]   cnt_inc  [WIDTH];
  logic [CNT_W:0]   len_eff;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;

  assign s = sync_q[SYNC_STAGES-1];

  // A zero length behaves as one; one extra bit keeps cnt+1 from wrapping.
  assign len_eff = (stable_len == '0) ? ONE_W : {1'b0, stable_len};

  // Synchroniser chain: plain flop-to-flop, no logic between stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Stability qualification: count consecutive mismatch cycles, accept at L
  always_comb begin
    q_nxt    = q;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_inc[i] = {1'b0, cnt[i]} + ONE_W;
      cnt_nxt[i] = '0;
      if (s[i] != q[i]) begin
        if (cnt_inc[i] >= len_eff) begin
          q_nxt[i]    = s[i];
          rise_nxt[i] = s[i];
          fall_nxt[i] = ~s[i];
        end else begin
          cnt_nxt[i] = cnt_inc[i][CNT_W-1:0];
        end
      end
    end
  end

  // Filtered level, counters and edge strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      q    <= q_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef SM_INPUT_FILTER_EVT_EN
  logic [WIDTH-1:0] flags_q;

  // Sticky change flags; a new event in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= (flags_q & ~evt_clr) | rise | fall;
    end
  end

  assign evt_flags = flags_q;
  assign evt_any   = |flags_q;
`else
  logic evt_clr_unused;
  assign evt_clr_unused = ^evt_clr;
  assign evt_flags      = '0;
  assign evt_any        = 1'b0;
`endif

endmodule
